apb_axi_a_b_if: RTL and testbench

Bus-agent block bundling three controller-facing channel endpoints: an AXI address-channel master (usable for AR or AW), an AXI write-response (B) channel receiver, and an APB master for register access. It sits between the test/host command side and the DDR2 controller's APB and AXI ports. It converts simple request strobes into protocol-correct handshakes.

---
 rtl/apb_axi_a_b_if_if.sv | 77 +++++++
 rtl/apb_axi_a_b_if.sv | 201 ++++++++++++++++++++
 tb/tb_apb_axi_a_b_if.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_axi_a_b_if_if.sv
// Bundle of the command-side, AXI address/B and APB signals seen by the bus agent.
// The master modport is the agent's view; slave is the host/controller side.
interface apb_axi_a_b_if_if #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32
);
  logic                      a_req_valid;
  logic                      a_req_ready;
  logic [ID_WIDTH-1:0]       a_req_id;
  logic [ADDR_WIDTH-1:0]     a_req_addr;
  logic [7:0]                a_req_len;
  logic [2:0]                a_req_size;
  logic [1:0]                a_req_burst;

  logic                      avalid;
  logic                      aready;
  logic [ID_WIDTH-1:0]       aid;
  logic [ADDR_WIDTH-1:0]     aaddr;
  logic [7:0]                alen;
  logic [2:0]                asize;
  logic [1:0]                aburst;

  logic                      bvalid;
  logic                      bready;
  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      b_done;
  logic [ID_WIDTH-1:0]       b_id_o;
  logic [1:0]                b_resp_o;
  logic [7:0]                b_err_cnt;

  logic                      apb_req;
  logic                      apb_write;
  logic [APB_ADDR_WIDTH-1:0] apb_addr;
  logic [APB_DATA_WIDTH-1:0] apb_wdata;
  logic                      apb_busy;
  logic                      apb_done;
  logic [APB_DATA_WIDTH-1:0] apb_rdata;
  logic                      apb_err;

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pready;
  logic                      pslverr;
  logic [APB_DATA_WIDTH-1:0] prdata;

  modport master (
    input  a_req_valid, a_req_id, a_req_addr, a_req_len, a_req_size, a_req_burst,
    output a_req_ready,
    output avalid, aid, aaddr, alen, asize, aburst,
    input  aready,
    input  bvalid, bid, bresp,
    output bready, b_done, b_id_o, b_resp_o, b_err_cnt,
    input  apb_req, apb_write, apb_addr, apb_wdata,
    output apb_busy, apb_done, apb_rdata, apb_err,
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output a_req_valid, a_req_id, a_req_addr, a_req_len, a_req_size, a_req_burst,
    input  a_req_ready,
    input  avalid, aid, aaddr, alen, asize, aburst,
    output aready,
    output bvalid, bid, bresp,
    input  bready, b_done, b_id_o, b_resp_o, b_err_cnt,
    output apb_req, apb_write, apb_addr, apb_wdata,
    input  apb_busy, apb_done, apb_rdata, apb_err,
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_axi_a_b_if.sv
// Bus agent: buffered AXI address issuer, B-channel receiver and APB register master.
// rst_n is an asynchronous, active-high reset despite its name.
module apb_axi_a_b_if #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  apb_axi_a_b_if_if.master bus
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } cmd_t;

  cmd_t       fifo_q [2];
  cmd_t       acmd_q, acmd_d, cmdIn;
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ready_q, avalid_q, avalid_d;
  logic       push, pop;

  assign cmdIn = '{id: bus.a_req_id, addr: bus.a_req_addr, len: bus.a_req_len,
                   size: bus.a_req_size, burst: bus.a_req_burst};
  assign push  = bus.a_req_valid & ready_q;
  assign pop   = avalid_q & bus.aready;

  // The output register only ever loads entries stored before this edge, giving one cycle of latency.
  always_comb begin
    cnt_d    = cnt_q;
    wptr_d   = wptr_q ^ push;
    rptr_d   = rptr_q ^ pop;
    avalid_d = avalid_q;
    acmd_d   = acmd_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
    if (pop) begin
      if (cnt_q == 2'd2) begin
        avalid_d = 1'b1;
        acmd_d   = fifo_q[rptr_d];
      end else begin
        avalid_d = 1'b0;
      end
    end else if (!avalid_q && cnt_q != 2'd0) begin
      avalid_d = 1'b1;
      acmd_d   = fifo_q[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
      ready_q   <= 1'b1;
      avalid_q  <= 1'b0;
      acmd_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= cmdIn;
      end
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= (cnt_d != 2'd2);
      avalid_q <= avalid_d;
      acmd_q   <= acmd_d;
    end
  end

  assign bus.a_req_ready = ready_q;
  assign bus.avalid      = avalid_q;
  assign bus.aid         = acmd_q.id;
  assign bus.aaddr       = acmd_q.addr;
  assign bus.alen        = acmd_q.len;
  assign bus.asize       = acmd_q.size;
  assign bus.aburst      = acmd_q.burst;

  logic                bready_q, bDone_q, bHs;
  logic [ID_WIDTH-1:0] bId_q;
  logic [1:0]          bResp_q;
  logic [7:0]          bErrCnt_q;

  assign bHs = bus.bvalid & bready_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bready_q  <= 1'b1;
      bDone_q   <= 1'b0;
      bId_q     <= '0;
      bResp_q   <= 2'b00;
      bErrCnt_q <= 8'd0;
    end else begin
      bready_q <= 1'b1;
      bDone_q  <= bHs;
      if (bHs) begin
        bId_q   <= bus.bid;
        bResp_q <= bus.bresp;
        if (bus.bresp != 2'b00 && bErrCnt_q != 8'hFF) begin
          bErrCnt_q <= bErrCnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.bready    = bready_q;
  assign bus.b_done    = bDone_q;
  assign bus.b_id_o    = bId_q;
  assign bus.b_resp_o  = bResp_q;
  assign bus.b_err_cnt = bErrCnt_q;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  apb_state_e                state_q, state_d;
  logic                      psel_q, penable_q, busy_q;
  logic                      done_q, done_d, err_q, err_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      IDLE: begin
        if (bus.apb_req) begin
          pwrite_d = bus.apb_write;
          paddr_d  = bus.apb_addr;
          pwdata_d = bus.apb_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done_d  = 1'b1;
          err_d   = bus.pslverr;
          state_d = IDLE;
          if (!pwrite_q) begin
            rdata_d = bus.prdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they line up with the FSM phase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.apb_busy  = busy_q;
  assign bus.apb_done  = done_q;
  assign bus.apb_rdata = rdata_q;
  assign bus.apb_err   = err_q;

endmodule

// File: tb/tb_apb_axi_a_b_if.sv
// Randomized bench for apb_axi_a_b_if with a transaction-level reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_axi_a_b_if;

  logic clk;
  logic rst_n;

  apb_axi_a_b_if_if bus ();

  apb_axi_a_b_if dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          acc;
  } mcmd_t;

  mcmd_t       aq[$];
  int          edgeCnt;
  logic        mBdone;
  logic [3:0]  mBid;
  logic [1:0]  mBresp;
  int          mErr;
  logic        mActive;
  int          mAge;
  logic        mPwrite;
  logic [11:0] mPaddr;
  logic [31:0] mPwdata;
  logic        mDone;
  logic [31:0] mRdata;
  logic        mApbErr;

  int checkCnt = 0;
  int passCnt  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    aq.delete();
    edgeCnt = 0;
    mBdone  = 0; mBid = 0; mBresp = 0; mErr = 0;
    mActive = 0; mAge = 0; mPwrite = 0; mPaddr = 0; mPwdata = 0;
    mDone   = 0; mRdata = 0; mApbErr = 0;
  endtask

  task automatic driveIdle();
    bus.a_req_valid = 0; bus.a_req_id = 0; bus.a_req_addr = 0;
    bus.a_req_len = 0; bus.a_req_size = 0; bus.a_req_burst = 0;
    bus.aready = 0; bus.bvalid = 0; bus.bid = 0; bus.bresp = 0;
    bus.apb_req = 0; bus.apb_write = 0; bus.apb_addr = 0; bus.apb_wdata = 0;
    bus.pready = 0; bus.pslverr = 0; bus.prdata = 0;
  endtask

  task automatic setCmd(input int i);
    bus.a_req_id    = 4'(i + 1);
    bus.a_req_addr  = 32'h100 + 32'(i * 4);
    bus.a_req_len   = 8'(i);
    bus.a_req_size  = 3'd2;
    bus.a_req_burst = 2'd1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_avalid"},  bus.avalid, 0);
    checkOutput({tag, "_aid"},     bus.aid, 0);
    checkOutput({tag, "_aaddr"},   bus.aaddr, 0);
    checkOutput({tag, "_alen"},    bus.alen, 0);
    checkOutput({tag, "_ardy"},    bus.a_req_ready, 1);
    checkOutput({tag, "_bready"},  bus.bready, 1);
    checkOutput({tag, "_bdone"},   bus.b_done, 0);
    checkOutput({tag, "_bid"},     bus.b_id_o, 0);
    checkOutput({tag, "_berrcnt"}, bus.b_err_cnt, 0);
    checkOutput({tag, "_psel"},    bus.psel, 0);
    checkOutput({tag, "_penable"}, bus.penable, 0);
    checkOutput({tag, "_pwrite"},  bus.pwrite, 0);
    checkOutput({tag, "_paddr"},   bus.paddr, 0);
    checkOutput({tag, "_pwdata"},  bus.pwdata, 0);
    checkOutput({tag, "_busy"},    bus.apb_busy, 0);
    checkOutput({tag, "_apbdone"}, bus.apb_done, 0);
    checkOutput({tag, "_rdata"},   bus.apb_rdata, 0);
    checkOutput({tag, "_apberr"},  bus.apb_err, 0);
  endtask

  // A command is visible on the address bus from the cycle after its acceptance, oldest first.
  function automatic logic modelAvalid();
    return (aq.size() > 0) && (aq[0].acc <= edgeCnt - 1);
  endfunction

  task automatic compareAll();
    logic expAv;
    expAv = modelAvalid();
    checkOutput("a_req_ready", bus.a_req_ready, (aq.size() < 2));
    checkOutput("avalid", bus.avalid, expAv);
    if (expAv) begin
      checkOutput("aid",    bus.aid,    aq[0].id);
      checkOutput("aaddr",  bus.aaddr,  aq[0].addr);
      checkOutput("alen",   bus.alen,   aq[0].len);
      checkOutput("asize",  bus.asize,  aq[0].size);
      checkOutput("aburst", bus.aburst, aq[0].burst);
    end
    checkOutput("bready",    bus.bready, 1);
    checkOutput("b_done",    bus.b_done, mBdone);
    checkOutput("b_id_o",    bus.b_id_o, mBid);
    checkOutput("b_resp_o",  bus.b_resp_o, mBresp);
    checkOutput("b_err_cnt", bus.b_err_cnt, mErr);
    checkOutput("psel",      bus.psel, mActive);
    checkOutput("penable",   bus.penable, (mActive && mAge >= 2));
    checkOutput("apb_busy",  bus.apb_busy, mActive);
    checkOutput("pwrite",    bus.pwrite, mPwrite);
    checkOutput("paddr",     bus.paddr, mPaddr);
    checkOutput("pwdata",    bus.pwdata, mPwdata);
    checkOutput("apb_done",  bus.apb_done, mDone);
    checkOutput("apb_rdata", bus.apb_rdata, mRdata);
    checkOutput("apb_err",   bus.apb_err, mApbErr);
  endtask

  task automatic modelStep();
    logic av, rdy, doPop, doPush;
    mcmd_t c;
    av     = modelAvalid();
    rdy    = (aq.size() < 2);
    doPop  = av && bus.aready;
    doPush = bus.a_req_valid && rdy;
    edgeCnt++;
    if (doPop) void'(aq.pop_front());
    if (doPush) begin
      c.id = bus.a_req_id; c.addr = bus.a_req_addr; c.len = bus.a_req_len;
      c.size = bus.a_req_size; c.burst = bus.a_req_burst; c.acc = edgeCnt;
      aq.push_back(c);
    end
    mBdone = bus.bvalid;
    if (bus.bvalid) begin
      mBid   = bus.bid;
      mBresp = bus.bresp;
      if (bus.bresp != 2'b00 && mErr < 255) mErr++;
    end
    mDone = 0;
    if (!mActive) begin
      if (bus.apb_req) begin
        mActive = 1; mAge = 1;
        mPwrite = bus.apb_write; mPaddr = bus.apb_addr; mPwdata = bus.apb_wdata;
      end
    end else if (mAge >= 2 && bus.pready) begin
      mActive = 0; mDone = 1; mApbErr = bus.pslverr;
      if (!mPwrite) mRdata = bus.prdata;
    end else begin
      mAge++;
    end
  endtask

  task automatic applyStimulus();
    compareAll();
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    int idx, penCnt, doneCnt;
    logic accepted;
    clk = 0;
    rst_n = 1;
    driveIdle();
    repeat (3) @(negedge clk);
    checkResetValues("por");
    rst_n = 0;
    resetModel();

    // Two back-to-back commands drained with aready high.
    bus.aready = 1;
    bus.a_req_valid = 1;
    bus.a_req_id = 0; bus.a_req_addr = 32'h0; bus.a_req_len = 0; bus.a_req_size = 0; bus.a_req_burst = 0;
    applyStimulus();
    bus.a_req_addr = 32'h4;
    applyStimulus();
    bus.a_req_valid = 0;
    repeat (4) applyStimulus();

    // Three commands against a stalled address channel.
    bus.aready = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      bus.a_req_valid = (idx < 3);
      setCmd(idx);
      accepted = (idx < 3) && (aq.size() < 2);
      applyStimulus();
      if (accepted) idx++;
    end
    checkOutput("stall_accepted", idx, 2);
    checkOutput("stall_ready_low", bus.a_req_ready, 0);
    bus.aready = 1;
    for (int c = 0; c < 8; c++) begin
      bus.a_req_valid = (idx < 3);
      setCmd(idx);
      accepted = (idx < 3) && (aq.size() < 2);
      applyStimulus();
      if (accepted) idx++;
    end
    bus.a_req_valid = 0;
    checkOutput("stall_all_issued", bus.avalid, 0);

    // Two write responses, the second an error.
    bus.bvalid = 1; bus.bid = 4'd3; bus.bresp = 2'd0;
    applyStimulus();
    bus.bvalid = 0;
    applyStimulus();
    bus.bvalid = 1; bus.bid = 4'd5; bus.bresp = 2'd2;
    applyStimulus();
    bus.bvalid = 0;
    applyStimulus();
    checkOutput("b_last_id", bus.b_id_o, 5);
    checkOutput("b_last_resp", bus.b_resp_o, 2);
    checkOutput("b_errs", bus.b_err_cnt, 1);

    // APB write with three wait states.
    bus.apb_req = 1; bus.apb_write = 1; bus.apb_addr = 12'h010; bus.apb_wdata = 32'hDEADBEEF;
    applyStimulus();
    bus.apb_req = 0;
    penCnt = 0; doneCnt = 0;
    for (int c = 0; c < 10; c++) begin
      bus.pready = mActive && (mAge == 5);
      if (bus.penable) penCnt++;
      if (bus.apb_done) doneCnt++;
      applyStimulus();
    end
    checkOutput("wr_penable_cycles", penCnt, 4);
    checkOutput("wr_done_pulses", doneCnt, 1);
    checkOutput("wr_err", bus.apb_err, 0);

    // APB read returning a slave error.
    bus.apb_req = 1; bus.apb_write = 0; bus.apb_addr = 12'h004;
    bus.prdata = 32'h12345678; bus.pslverr = 1; bus.pready = 1;
    applyStimulus();
    bus.apb_req = 0;
    repeat (3) applyStimulus();
    checkOutput("rd_rdata", bus.apb_rdata, 32'h12345678);
    checkOutput("rd_err", bus.apb_err, 1);
    bus.pslverr = 0; bus.pready = 0;

    // Random traffic on all three channels.
    for (int c = 0; c < 400; c++) begin
      bus.a_req_valid = 1'($urandom_range(0, 1));
      bus.a_req_id    = 4'($urandom);
      bus.a_req_addr  = $urandom;
      bus.a_req_len   = 8'($urandom);
      bus.a_req_size  = 3'($urandom);
      bus.a_req_burst = 2'($urandom);
      bus.aready      = ($urandom_range(0, 9) < 6);
      bus.bvalid      = 1'($urandom_range(0, 1));
      bus.bid         = 4'($urandom);
      bus.bresp       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.apb_req     = ($urandom_range(0, 9) < 3);
      bus.apb_write   = 1'($urandom_range(0, 1));
      bus.apb_addr    = 12'($urandom);
      bus.apb_wdata   = $urandom;
      bus.pready      = ($urandom_range(0, 9) < 4);
      bus.pslverr     = 1'($urandom_range(0, 1));
      bus.prdata      = $urandom;
      applyStimulus();
    end

    // Error counter saturation.
    driveIdle();
    bus.pready = 1;
    bus.bvalid = 1;
    for (int c = 0; c < 260; c++) begin
      bus.bid   = 4'($urandom);
      bus.bresp = 2'($urandom_range(1, 3));
      applyStimulus();
    end
    bus.bvalid = 0;
    applyStimulus();
    checkOutput("b_err_saturated", bus.b_err_cnt, 255);
    repeat (3) applyStimulus();

    // Reset with the FIFO full and an APB read stalled in ACCESS.
    driveIdle();
    bus.apb_req = 1; bus.apb_write = 0; bus.apb_addr = 12'h0AC;
    bus.a_req_valid = 1;
    for (int c = 0; c < 3; c++) begin
      setCmd(c + 7);
      applyStimulus();
      bus.apb_req = 0;
    end
    checkOutput("pre_rst_full", bus.a_req_ready, 0);
    checkOutput("pre_rst_access", bus.penable, 1);
    #2 rst_n = 1;
    #1 checkResetValues("midrst");
    @(posedge clk);
    #1 checkOutput("rst_hold_apbdone", bus.apb_done, 0);
    @(negedge clk);
    rst_n = 0;
    resetModel();
    driveIdle();
    bus.pready = 1;
    repeat (3) applyStimulus();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
